// File: rtl/daw_vga_pkg.sv
// Shared timing constants and the registered raster bundle for the VGA timing generator.
// Defaults describe 640x480@60 Hz with a 25 MHz pixel clock.
package daw_vga_pkg;

    localparam int COORD_W = 10;
    localparam int FC_W    = 16;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int total_len(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    localparam int H_TOTAL_DEF      = total_len(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF      = total_len(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
    localparam int H_SYNC_START_DEF = sync_start(H_ACTIVE_DEF, H_FP_DEF);
    localparam int H_SYNC_END_DEF   = sync_end(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
    localparam int V_SYNC_START_DEF = sync_start(V_ACTIVE_DEF, V_FP_DEF);
    localparam int V_SYNC_END_DEF   = sync_end(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               active;
        logic               hs;
        logic               vs;
        logic               line_start;
        logic               frame_start;
    } raster_t;

    localparam raster_t RASTER_RESET = '{
        x:           '0,
        y:           '0,
        active:      1'b0,
        hs:          1'b1,
        vs:          1'b1,
        line_start:  1'b0,
        frame_start: 1'b0
    };

endpackage

// File: rtl/daw_vga_timing_counter.sv
// Modulo-N counter with synchronous clear and enable; wrap marks the terminal count.
// wrap is not gated by en so callers can chain it into the next counter's enable.
module daw_mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
    assign wrap  = (count_reg == LAST);

endmodule

// File: rtl/daw_vga_timing.sv
// VGA raster timing generator: counter stage followed by one registered decode stage,
// so every output reflects the counter pair from the previous enabled edge.
module daw_vga_timing
    import daw_vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic               vga_clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] xPixel,
    output logic [COORD_W-1:0] yPixel,
    output logic               active_pixels,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic               line_start,
    output logic               frame_start,
    output logic [FC_W-1:0]    frame_count
);

    localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SS_C  = COORD_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [COORD_W-1:0] H_SE_C  = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [COORD_W-1:0] V_SS_C  = COORD_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [COORD_W-1:0] V_SE_C  = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;
    logic               v_en;

    raster_t            raster_reg;
    raster_t            raster_next;
    logic [FC_W-1:0]    frame_count_reg;

    assign v_en = pix_en & h_wrap;

    daw_mod_counter #(
        .MODULUS(H_TOTAL),
        .WIDTH  (COORD_W)
    ) u_h_counter (
        .clk  (vga_clk),
        .clear(rst),
        .en   (pix_en),
        .count(h_cnt),
        .wrap (h_wrap)
    );

    daw_mod_counter #(
        .MODULUS(V_TOTAL),
        .WIDTH  (COORD_W)
    ) u_v_counter (
        .clk  (vga_clk),
        .clear(rst),
        .en   (v_en),
        .count(v_cnt),
        .wrap (v_wrap)
    );

    always_comb begin
        raster_next             = RASTER_RESET;
        raster_next.x           = h_cnt;
        raster_next.y           = v_cnt;
        raster_next.active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        raster_next.hs          = !((h_cnt >= H_SS_C) && (h_cnt < H_SE_C));
        raster_next.vs          = !((v_cnt >= V_SS_C) && (v_cnt < V_SE_C));
        raster_next.line_start  = (h_cnt == '0);
        raster_next.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Pulses are cleared on stalled cycles so a held pixel never repeats a strobe.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            raster_reg      <= RASTER_RESET;
            frame_count_reg <= '0;
        end else if (pix_en) begin
            raster_reg <= raster_next;
            if (h_wrap && v_wrap) begin
                frame_count_reg <= frame_count_reg + FC_W'(1);
            end
        end else begin
            raster_reg.line_start  <= 1'b0;
            raster_reg.frame_start <= 1'b0;
        end
    end

    assign xPixel        = raster_reg.x;
    assign yPixel        = raster_reg.y;
    assign active_pixels = raster_reg.active;
    assign VGA_BLANK_N   = raster_reg.active;
    assign VGA_HS        = raster_reg.hs;
    assign VGA_VS        = raster_reg.vs;
    assign VGA_SYNC_N    = 1'b0;
    assign line_start    = raster_reg.line_start;
    assign frame_start   = raster_reg.frame_start;
    assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_daw_vga_timing.sv
// Scoreboard bench: a default 640x480 instance and a tiny-raster instance share the stimulus.
module tb_daw_vga_timing;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    logic [9:0]  x0, y0, x1, y1;
    logic        act0, hs0, vs0, bl0, sn0, ls0, fs0;
    logic        act1, hs1, vs1, bl1, sn1, ls1, fs1;
    logic [15:0] fc0, fc1;

    always #5 clk = ~clk;

    daw_vga_timing u_dut0 (
        .vga_clk(clk), .rst(rst), .pix_en(pix_en),
        .xPixel(x0), .yPixel(y0), .active_pixels(act0),
        .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bl0), .VGA_SYNC_N(sn0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
    );

    daw_vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut1 (
        .vga_clk(clk), .rst(rst), .pix_en(pix_en),
        .xPixel(x1), .yPixel(y1), .active_pixels(act1),
        .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1), .VGA_SYNC_N(sn1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
    );

    int n_checks = 0;
    int n_errors = 0;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int   m_h[2];
    int   m_v[2];
    obs_t m_o[2];

    // Run-length trackers, measured from observed outputs on enabled edges only.
    int en_cnt;
    int hs0_run, ls0_last, vs1_run, fs1_last;
    logic hs0_prev, vs1_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference raster: expected outputs after the coming edge, from the pre-edge counters.
    task automatic model_step(input int k, input logic r, input logic en);
        int ha, hss, hse, ht, va, vss, vse, vt;
        if (k == 0) begin
            ha = 640; hss = 656; hse = 752; ht = 800;
            va = 480; vss = 490; vse = 492; vt = 525;
        end else begin
            ha = 4; hss = 5; hse = 7; ht = 8;
            va = 3; vss = 4; vse = 5; vt = 6;
        end
        if (r) begin
            m_h[k] = 0;
            m_v[k] = 0;
            m_o[k] = '{x: 10'd0, y: 10'd0, act: 1'b0, hs: 1'b1, vs: 1'b1,
                       blank: 1'b0, sync: 1'b0, ls: 1'b0, fs: 1'b0, fc: 16'd0};
        end else if (en) begin
            m_o[k].x     = 10'(m_h[k]);
            m_o[k].y     = 10'(m_v[k]);
            m_o[k].act   = (m_h[k] < ha) && (m_v[k] < va);
            m_o[k].blank = m_o[k].act;
            m_o[k].hs    = !((m_h[k] >= hss) && (m_h[k] < hse));
            m_o[k].vs    = !((m_v[k] >= vss) && (m_v[k] < vse));
            m_o[k].ls    = (m_h[k] == 0);
            m_o[k].fs    = (m_h[k] == 0) && (m_v[k] == 0);
            if (m_h[k] == ht - 1 && m_v[k] == vt - 1) m_o[k].fc = m_o[k].fc + 16'd1;
            if (m_h[k] == ht - 1) begin
                m_h[k] = 0;
                m_v[k] = (m_v[k] == vt - 1) ? 0 : m_v[k] + 1;
            end else begin
                m_h[k] = m_h[k] + 1;
            end
        end else begin
            m_o[k].ls = 1'b0;
            m_o[k].fs = 1'b0;
        end
    endtask

    task automatic compare_obs(input int k, input obs_t g, input obs_t e);
        check_val($sformatf("d%0d_x", k),      32'(g.x),     32'(e.x));
        check_val($sformatf("d%0d_y", k),      32'(g.y),     32'(e.y));
        check_val($sformatf("d%0d_active", k), 32'(g.act),   32'(e.act));
        check_val($sformatf("d%0d_hs", k),     32'(g.hs),    32'(e.hs));
        check_val($sformatf("d%0d_vs", k),     32'(g.vs),    32'(e.vs));
        check_val($sformatf("d%0d_blank", k),  32'(g.blank), 32'(e.blank));
        check_val($sformatf("d%0d_sync", k),   32'(g.sync),  32'(e.sync));
        check_val($sformatf("d%0d_ls", k),     32'(g.ls),    32'(e.ls));
        check_val($sformatf("d%0d_fs", k),     32'(g.fs),    32'(e.fs));
        check_val($sformatf("d%0d_fc", k),     32'(g.fc),    32'(e.fc));
    endtask

    task automatic track_runs(input logic r, input logic en);
        if (r) begin
            en_cnt = 0;
            hs0_run = 0; hs0_prev = 1'b1; ls0_last = -1;
            vs1_run = 0; vs1_prev = 1'b1; fs1_last = -1;
        end else if (en) begin
            en_cnt++;
            if (!hs0) begin
                if (hs0_prev) check_val("hs0_start_x", 32'(x0), 32'd656);
                hs0_run++;
            end else if (!hs0_prev) begin
                check_val("hs0_len", 32'(hs0_run), 32'd96);
                hs0_run = 0;
            end
            hs0_prev = hs0;
            if (ls0) begin
                if (ls0_last >= 0) check_val("ls0_period", 32'(en_cnt - ls0_last), 32'd800);
                ls0_last = en_cnt;
            end
            if (!vs1) begin
                if (vs1_prev) begin
                    check_val("vs1_start_y", 32'(y1), 32'd4);
                    check_val("vs1_start_x", 32'(x1), 32'd0);
                end
                vs1_run++;
            end else if (!vs1_prev) begin
                check_val("vs1_len", 32'(vs1_run), 32'd8);
                vs1_run = 0;
            end
            vs1_prev = vs1;
            if (fs1) begin
                if (fs1_last >= 0) check_val("fs1_period", 32'(en_cnt - fs1_last), 32'd48);
                fs1_last = en_cnt;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic en);
        obs_t g0, g1, e0, e1;
        @(negedge clk);
        rst    = r;
        pix_en = en;
        model_step(0, r, en);
        model_step(1, r, en);
        exp_q0.push_back(m_o[0]);
        exp_q1.push_back(m_o[1]);
        @(posedge clk);
        #1;
        g0 = '{x: x0, y: y0, act: act0, hs: hs0, vs: vs0, blank: bl0,
               sync: sn0, ls: ls0, fs: fs0, fc: fc0};
        g1 = '{x: x1, y: y1, act: act1, hs: hs1, vs: vs1, blank: bl1,
               sync: sn1, ls: ls1, fs: fs1, fc: fc1};
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            compare_obs(0, g0, e0);
            compare_obs(1, g1, e1);
        end
        track_runs(r, en);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        pix_en = 1'b0;
        m_h = '{0, 0};
        m_v = '{0, 0};
        m_o = '{default: '0};

        $display("phase: reset then first three enabled edges");
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check_val("startup_x", 32'(x0), 32'd2);

        $display("phase: continuous enable, 2000 cycles");
        for (int i = 0; i < 2000; i++) cycle(1'b0, 1'b1);
        check_val("small_frames_seen", 32'(fc1 > 16'd30), 32'd1);

        $display("phase: alternating enable, 600 cycles");
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'(i % 2 == 0));

        $display("phase: random enable, 600 cycles");
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'($urandom_range(0, 3) != 0));

        $display("phase: reset mid-frame at xPixel=300");
        n = 0;
        while (x0 != 10'd300 && n < 1000) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        check_val("reach_x300", 32'(x0), 32'd300);
        check_val("fc1_nonzero_before_rst", 32'(fc1 != 16'd0), 32'd1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        check_val("restart_fs0", 32'(fs0), 32'd1);

        $display("phase: continuous enable after reset, 300 cycles");
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/daw_vga_timing.md
# daw_vga_timing

Pixel-timing generator for the DAW display path. It produces the 640x480@60 Hz raster (pixel coordinates, active-video flag, and sync/blank strobes) from a 25 MHz pixel clock. It sits directly upstream of the main-screen renderer, which consumes `xPixel`, `yPixel` and `active_pixels`. The sync outputs go straight to the VGA DAC pins.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels (H_TOTAL = 800)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines (V_TOTAL = 525)
- `vga_clk` in 1: pixel clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset
- `pix_en` in 1: pixel advance enable. Tie to 1 when `vga_clk` is 25 MHz.
- `xPixel` out 10: horizontal position, 0..H_TOTAL-1
- `yPixel` out 10: vertical position, 0..V_TOTAL-1
- `active_pixels` out 1: high inside the visible region
- `VGA_HS` out 1: horizontal sync, active low
- `VGA_VS` out 1: vertical sync, active low
- `VGA_BLANK_N` out 1: equal to `active_pixels`
- `VGA_SYNC_N` out 1: constant 0
- `line_start` out 1: one-cycle pulse at x=0
- `frame_start` out 1: one-cycle pulse at x=0, y=0
- `frame_count` out 16: number of completed frames, modulo 2^16

## Operation
- Two internal counters:
  - `h_cnt` runs 0..H_TOTAL-1.
  - `v_cnt` runs 0..V_TOTAL-1 and advances only when `h_cnt` wraps.
- Both counters advance only on cycles where `pix_en`=1.
- Output decode from the counter pair (h, v):
  - active = (h < H_ACTIVE) and (v < V_ACTIVE)
  - HS low when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - VS low when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for all h in those lines
  - `line_start` = (h==0)
  - `frame_start` = (h==0 and v==0)
- `xPixel`/`yPixel` carry the raw counter values, including blanking values. Downstream logic must gate on `active_pixels`.
- `frame_count` increments on the enabled edge where h=H_TOTAL-1 and v=V_TOTAL-1. It wraps 65535→0.
- When `pix_en`=0:
  - counters and all level outputs hold their values
  - `line_start` and `frame_start` are driven 0, so no pulse is ever duplicated
- Reset values:
  - counters 0
  - `xPixel` 0, `yPixel` 0
  - `active_pixels` 0, `VGA_BLANK_N` 0
  - `VGA_HS` 1, `VGA_VS` 1
  - `line_start` 0, `frame_start` 0
  - `frame_count` 0
- Reset asserted mid-frame: on the next edge all outputs take their reset values. The raster then restarts at (0,0), with no partial-frame increment of `frame_count`.

## Timing
- Stage 1 holds the registered counters. Stage 2 holds the registered outputs: all outputs are decoded from the stage-1 counters and registered together, so they are mutually aligned and glitch-free.
- Latency: outputs reflect the counter value from one enabled edge earlier.
- Startup: the first enabled edge after `rst` deasserts produces xPixel=0, yPixel=0, active_pixels=1, line_start=1, frame_start=1.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL×V_TOTAL = 420000 enabled cycles.
- `rst` takes priority over `pix_en`.

## Structure
- Package `daw_vga_pkg` holds:
  - the default timing constants
  - derived H_TOTAL, V_TOTAL and the sync start/end localparams
- Sub-module `daw_mod_counter`:
  - parameterised modulus, synchronous clear, enable input
  - outputs: count value and a `wrap` flag
  - instantiated twice: horizontal (enabled by `pix_en`) and vertical (enabled by `pix_en` and the horizontal `wrap`)

## Test plan
- Reset, then 3 enabled edges → xPixel 0,1,2; yPixel 0; active_pixels 1; frame_start high only on the first of these edges.
- One full line → active_pixels falls when xPixel=640. VGA_HS is low for exactly 96 enabled cycles, starting at xPixel=656. line_start repeats every 800 cycles.
- One full frame → frame_start pulses are 420000 cycles apart. VGA_VS is low for exactly 1600 cycles, starting at yPixel=490, xPixel=0. frame_count goes 0→1.
- `pix_en` alternating 1/0 → each output value lasts 2 clocks. Outputs hold on disabled cycles. Pulses are exactly 1 clock wide and there are no duplicates.
- `rst` pulsed at xPixel=300, yPixel=200 → the next outputs are the reset values. The following enabled edge gives (0,0) with frame_start=1. frame_count stays unchanged.
- Small parameters (H: 4/1/2/1, V: 3/1/1/1) → frame period 8×6=48 cycles. Sync windows are at x=5..6 and y=4. frame_count wraps 65535→0 after 65536 frames.
